// File: rtl/hilo_mdu_if.sv
// Command and result bundle between the instruction decoder and the HI/LO multiply unit.
// The master drives commands and abort; the slave returns the stall, completion and HI/LO values.
interface hilo_mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, abort,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, abort,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO register pair with a radix-2 shift-add multiplier (MULT/MULTU) and MTHI/MTLO writes.
// A multiply takes WIDTH CALC cycles plus one FIN cycle; busy stalls the pipeline meanwhile.
module hilo_mdu #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   hilo_mdu_if.slave mdu
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               neg_flag;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   rs_mag;
   logic [WIDTH-1:0]   rt_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] product;

   // Magnitudes of 0x80..0 wrap back to 0x80..0, which is the correct unsigned magnitude.
   always_comb begin
      rs_mag  = mdu.rs_data[WIDTH-1] ? (~mdu.rs_data + ONE) : mdu.rs_data;
      rt_mag  = mdu.rt_data[WIDTH-1] ? (~mdu.rt_data + ONE) : mdu.rt_data;
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      product = neg_flag ? (~acc + ONE2) : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         neg_flag <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (mdu.start && !mdu.abort) begin
                  case (mdu.op)
                     2'b10: hi_q <= mdu.rs_data;
                     2'b11: lo_q <= mdu.rs_data;
                     2'b00: begin
                        mcand    <= rs_mag;
                        mplier   <= rt_mag;
                        neg_flag <= mdu.rs_data[WIDTH-1] ^ mdu.rt_data[WIDTH-1];
                        acc      <= '0;
                        count    <= '0;
                        state    <= CALC;
                        busy_q   <= 1'b1;
                     end
                     default: begin
                        mcand    <= mdu.rs_data;
                        mplier   <= mdu.rt_data;
                        neg_flag <= 1'b0;
                        acc      <= '0;
                        count    <= '0;
                        state    <= CALC;
                        busy_q   <= 1'b1;
                     end
                  endcase
               end
            end
            CALC: begin
               if (mdu.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  // The carry out of the add becomes the new top bit after the shift.
                  acc    <= {sum, acc[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
                  if (count == CW'(WIDTH - 1)) begin
                     state <= FIN;
                  end
               end
            end
            FIN: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               if (!mdu.abort) begin
                  hi_q   <= product[2*WIDTH-1:WIDTH];
                  lo_q   <= product[WIDTH-1:0];
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign mdu.busy = busy_q;
   assign mdu.done = done_q;
   assign mdu.hi   = hi_q;
   assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: directed multiplies push expected HI/LO, a monitor checks on done.
module tb_hilo_mdu;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   hilo_mdu_if #(.WIDTH(W)) bus ();

   hilo_mdu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mdu   (bus)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives a command immediately and holds it across exactly one rising edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = rs;
      bus.rt_data = rt;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic waitDone(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            lat = k;
            return;
         end
      end
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: no done within 100 cycles, expected one");
   endtask

   task automatic countDone(input int cycles, output int seen);
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: done=1, expected 0");
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_hi", bus.hi, mon_e.hi);
            checkOutput("sb_lo", bus.lo, mon_e.lo);
         end
      end
   end

   initial begin
      int lat;
      int bc;
      int seen;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.abort   = 1'b0;

      #3;
      checkOutput("reset_hi", bus.hi, 0);
      checkOutput("reset_lo", bus.lo, 0);
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned corner product and exact busy/done timing.
      @(negedge clk);
      exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone(lat, bc);
      checkOutput("multu_latency", lat, 34);
      checkOutput("multu_busy_cycles", bc, 33);
      checkOutput("busy_at_done", bus.busy, 0);

      // Signed multiply, then a back-to-back start in the done cycle.
      @(negedge clk);
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
      waitDone(lat, bc);
      checkOutput("mult_neg_latency", lat, 34);
      exp_q.push_back({32'h4000_0000, 32'h0000_0000});
      applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000);
      waitDone(lat, bc);
      checkOutput("back_to_back_latency", lat, 34);

      // MTHI then MTLO on consecutive edges.
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 2'b10;
      bus.rs_data = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus.op      = 2'b11;
      bus.rs_data = 32'h9ABC_DEF0;
      @(negedge clk);
      checkOutput("mthi_hi", bus.hi, 32'h1234_5678);
      checkOutput("lo_before_mtlo", bus.lo, 32'h0000_0000);
      checkOutput("mthi_busy", bus.busy, 0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
      checkOutput("mtlo_hi_kept", bus.hi, 32'h1234_5678);
      checkOutput("mtlo_busy", bus.busy, 0);

      // Abort during CALC.
      @(negedge clk);
      applyStimulus(2'b00, 32'd7, 32'd6);
      repeat (9) @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_calc_busy", bus.busy, 0);
      countDone(40, seen);
      checkOutput("abort_calc_no_done", seen, 0);
      checkOutput("abort_calc_hi", bus.hi, 32'h1234_5678);
      checkOutput("abort_calc_lo", bus.lo, 32'h9ABC_DEF0);

      // Abort coinciding with FIN.
      @(negedge clk);
      applyStimulus(2'b00, 32'd7, 32'd6);
      repeat (33) @(negedge clk);
      checkOutput("busy_in_fin", bus.busy, 1);
      bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_fin_busy", bus.busy, 0);
      checkOutput("abort_fin_done", bus.done, 0);
      countDone(10, seen);
      checkOutput("abort_fin_no_done", seen, 0);
      checkOutput("abort_fin_hi", bus.hi, 32'h1234_5678);
      checkOutput("abort_fin_lo", bus.lo, 32'h9ABC_DEF0);

      // Abort in IDLE suppresses a same-cycle MTLO.
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 2'b11;
      bus.rs_data = 32'h0000_DEAD;
      bus.abort   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle_lo", bus.lo, 32'h9ABC_DEF0);

      // MTLO issued while busy is ignored.
      @(negedge clk);
      exp_q.push_back({32'h0000_0000, 32'h0000_4E20});
      applyStimulus(2'b01, 32'd100, 32'd200);
      repeat (5) @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 2'b11;
      bus.rs_data = 32'h0000_DEAD;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("busy_mtlo_ignored", bus.lo, 32'h9ABC_DEF0);
      waitDone(lat, bc);

      // Asynchronous reset mid-multiply, then a clean multiply.
      @(negedge clk);
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_hi", bus.hi, 0);
      checkOutput("midreset_lo", bus.lo, 0);
      checkOutput("midreset_busy", bus.busy, 0);
      checkOutput("midreset_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back({32'h0000_0000, 32'h0000_0006});
      applyStimulus(2'b01, 32'd2, 32'd3);
      waitDone(lat, bc);
      checkOutput("post_reset_latency", lat, 34);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
